// File: rtl/sfu_exp2_poly.sv
// Post-range-reduction exp2: splits Q8.23 x into k/frac, evaluates 2^frac by a piecewise quadratic
// from a writable table, packs IEEE754 single. Macro SFU_EXP2_RNE_EN selects RNE mantissa rounding.
module sfu_exp2_poly #(
    parameter int SEG_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data,
    input  logic                cfg_we,
    input  logic [SEG_BITS-1:0] cfg_addr,
    input  logic [60:0]         cfg_wdata
);
    localparam int DX_W  = 23 - SEG_BITS;
    localparam int SEGS  = 1 << SEG_BITS;
    localparam int SQ_W  = 2 * DX_W;
    localparam int T1P_W = 21 + DX_W;
    localparam int T2P_W = 14 + SQ_W;
    localparam int T1_W  = T1P_W - 18;
    localparam int T2_W  = T2P_W - 35;

    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // S1: coefficient table with registered read; write-then-read of one address yields the old word
    logic [60:0] r_coef_mem [SEGS];
    logic [60:0] r_coef;

    always_ff @(posedge clk) begin
        if (cfg_we) r_coef_mem[cfg_addr] <= cfg_wdata;
    end

    always_ff @(posedge clk) begin
        if (w_adv) r_coef <= r_coef_mem[in_data[22 -: SEG_BITS]];
    end

    logic [31:0] w_spec_word;
    always_comb begin
        w_spec_word = 32'h7FC0_0000;
        case (in_data[30:23])
            8'h0F:   w_spec_word = 32'h7F80_0000;
            8'hF0:   w_spec_word = 32'h0000_0000;
            8'h00:   w_spec_word = 32'h3F80_0000;
            8'hFF:   w_spec_word = {1'b0, 8'hFF, 1'b1, in_data[21:0]};
            default: w_spec_word = 32'h7FC0_0000;
        endcase
    end

    // Side-band per stage: valid, special flag, special result word, exponent k
    logic [4:1]      r_vld;
    logic [4:1]      r_spc;
    logic [31:0]     r_sw [1:4];
    logic [7:0]      r_k  [1:4];
    logic [DX_W-1:0] r_dx1;

    always_ff @(posedge clk) begin
        if (rst)        r_vld <= '0;
        else if (w_adv) r_vld <= {r_vld[3:1], in_valid};
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_spc   <= {r_spc[3:1], in_data[31]};
            r_sw[1] <= w_spec_word;
            r_k[1]  <= in_data[30:23];
            r_dx1   <= in_data[DX_W-1:0];
            for (int i = 2; i <= 4; i++) begin
                r_sw[i] <= r_sw[i-1];
                r_k[i]  <= r_k[i-1];
            end
        end
    end

    // S2: dx^2 kept exact; c1*dx truncated to Q1.25
    logic [SQ_W-1:0]  w_sq;
    logic [T1P_W-1:0] w_t1_full;
    logic [SQ_W-1:0]  r_sq2;
    logic [T1_W-1:0]  r_t1_2;
    logic [25:0]      r_c0_2;
    logic [13:0]      r_c2_2;

    assign w_sq      = {{DX_W{1'b0}}, r_dx1} * {{DX_W{1'b0}}, r_dx1};
    assign w_t1_full = {{DX_W{1'b0}}, r_coef[34:14]} * {{21{1'b0}}, r_dx1};

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_sq2  <= w_sq;
            r_t1_2 <= w_t1_full[T1P_W-1:18];
            r_c0_2 <= r_coef[60:35];
            r_c2_2 <= r_coef[13:0];
        end
    end

    // S3: c2*dx^2 truncated to Q1.25; s = c0 + t1
    logic [T2P_W-1:0] w_t2_full;
    logic [T2_W-1:0]  r_t2_3;
    logic [26:0]      r_s3;

    assign w_t2_full = {{SQ_W{1'b0}}, r_c2_2} * {{14{1'b0}}, r_sq2};

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_t2_3 <= w_t2_full[T2P_W-1:35];
            r_s3   <= {1'b0, r_c0_2} + {{(27-T1_W){1'b0}}, r_t1_2};
        end
    end

    // S4: p = s + t2 in Q1.25 (bit 25 = 1.0), then round to 23 fraction bits and saturate at 2.0
    logic [26:0] w_p;
    logic        w_sat;
    logic [22:0] w_mant;
    logic [22:0] r_mant4;
    logic        w_unused;

    assign w_p = r_s3 + {{(27-T2_W){1'b0}}, r_t2_3};

`ifdef SFU_EXP2_RNE_EN
    logic        w_up;
    logic [25:0] w_rnd;
    assign w_up     = w_p[1] & (w_p[0] | w_p[2]);
    assign w_rnd    = {1'b0, w_p[26:2]} + {25'b0, w_up};
    assign w_sat    = |w_rnd[25:24];
    assign w_mant   = w_sat ? 23'h7F_FFFF : w_rnd[22:0];
    assign w_unused = ^{w_t1_full[17:0], w_t2_full[34:0], w_rnd[23]};
`else
    assign w_sat    = w_p[26];
    assign w_mant   = w_sat ? 23'h7F_FFFF : w_p[24:2];
    assign w_unused = ^{w_t1_full[17:0], w_t2_full[34:0], w_p[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (w_adv) r_mant4 <= w_mant;
    end

    // Output: biased exponent; k of -127/-128 flushes to +0
    logic [8:0] w_e;
    logic       w_uflow;
    assign w_e     = {r_k[4][7], r_k[4]} + 9'd127;
    assign w_uflow = w_e[8] | (w_e == 9'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 32'h0;
        end else if (w_adv) begin
            out_valid <= r_vld[4];
            if (r_vld[4]) begin
                if (r_spc[4])     out_data <= r_sw[4];
                else if (w_uflow) out_data <= 32'h0;
                else              out_data <= {1'b0, w_e[7:0], r_mant4};
            end
        end
    end
endmodule

// File: tb/tb_sfu_exp2_poly.sv
// Self-checking bench for sfu_exp2_poly: directed vector table, corner sequences, randomized scoreboard run.
module tb_sfu_exp2_poly;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [60:0] cfg_wdata;

    always #5 clk = ~clk;

    sfu_exp2_poly #(.SEG_BITS(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_txn = 0;
    logic [31:0] sb[$];
    logic [31:0] cur_exp;
    logic [60:0] shadow [64];
    logic        rand_rdy = 1'b0;
    logic        have_hold = 1'b0;
    logic [31:0] held_data;

    localparam logic [60:0] COEF_ONE = {26'h200_0000, 21'h0, 14'h0};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Reference: 2^x from the coefficient formats with plain integer arithmetic
    function automatic logic [31:0] model(input logic [31:0] x);
        longint c0, c1, c2, dx, p, m;
        int k, e;
        logic [60:0] c;
        logic [22:0] frac;
        if (x[31]) begin
            case (x[30:23])
                8'h0F:   return 32'h7F80_0000;
                8'hF0:   return 32'h0000_0000;
                8'h00:   return 32'h3F80_0000;
                8'hFF:   return {1'b0, 8'hFF, 1'b1, x[21:0]};
                default: return 32'h7FC0_0000;
            endcase
        end
        k = int'($signed(x[30:23]));
        e = k + 127;
        if (e <= 0) return 32'h0;
        c  = shadow[x[22:17]];
        c0 = longint'(c[60:35]);
        c1 = longint'(c[34:14]);
        c2 = longint'(c[13:0]);
        dx = longint'(x[16:0]);
        p  = c0 + ((c1 * dx) >> 18) + ((c2 * dx * dx) >> 35);
`ifdef SFU_EXP2_RNE_EN
        m = p >> 2;
        if ((p & 3) == 3 || ((p & 3) == 2 && (m & 1) == 1)) m = m + 1;
        if (m >= (longint'(1) << 24)) frac = 23'h7F_FFFF;
        else                          frac = m[22:0];
`else
        if (p >= (longint'(1) << 26)) frac = 23'h7F_FFFF;
        else                          frac = p[24:2];
`endif
        return {1'b0, e[7:0], frac};
    endfunction

    // Monitor: each negedge reflects what the next rising edge will do
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            have_hold = 1'b0;
        end else begin
            if (out_valid) begin
                if (have_hold) check("hold_stable", out_data, held_data);
                if (!out_ready) begin
                    check("in_ready_held", {31'b0, in_ready}, 32'h0);
                    held_data = out_data;
                    have_hold = 1'b1;
                end else begin
                    have_hold = 1'b0;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out: got %08h expected none", out_data);
                    end else begin
                        logic [31:0] e;
                        e = sb.pop_front();
                        n_txn++;
                        $display("txn %0d: out %08h exp %08h", n_txn, out_data, e);
                        check("out_data", out_data, e);
                    end
                end
            end else begin
                have_hold = 1'b0;
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
        if (cfg_we) shadow[cfg_addr] = cfg_wdata;
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Drivers run at posedge+1 and return at posedge+1
    task automatic send(input logic [31:0] d, input logic [31:0] e);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        cur_exp  = e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [60:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 32'(sb.size()), 32'h0);
    endtask

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vec_t vecs[12];
        logic [31:0] rnd_exp;
        int seen;
        vecs[0]  = '{32'h0080_0000, 32'h4000_0000};
        vecs[1]  = '{32'h7F80_0000, 32'h3F00_0000};
        vecs[2]  = '{32'h8780_0000, 32'h7F80_0000};
        vecs[3]  = '{32'hF800_0000, 32'h0000_0000};
        vecs[4]  = '{32'h8000_0000, 32'h3F80_0000};
        vecs[5]  = '{32'hFFC0_0001, 32'h7FC0_0001};
        vecs[6]  = '{32'h8100_0000, 32'h7FC0_0000};
        vecs[7]  = '{32'h4080_0000, 32'h0000_0000};
        vecs[8]  = '{32'h4000_0000, 32'h0000_0000};
        vecs[9]  = '{32'h3F80_0000, 32'h7F00_0000};
        vecs[10] = '{32'h0000_0000, 32'h3F80_0000};
        vecs[11] = '{32'h7F7F_FFFF, 32'h3E80_0000};
`ifdef SFU_EXP2_RNE_EN
        rnd_exp = 32'h3F80_0001;
`else
        rnd_exp = 32'h3F80_0000;
`endif

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cur_exp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;

        for (int a = 0; a < 64; a++) cfg_write(6'(a), COEF_ONE);

        for (int i = 0; i < 12; i++) send(vecs[i].din, vecs[i].dout);
        wait_drain();

        // Latency: accepted at edge T, first visible at edge T+4
        in_valid = 1'b1; in_data = 32'h0080_0000; cur_exp = 32'h4000_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("latency_early", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("latency_t4", {31'b0, out_valid}, 32'h1);
        wait_drain();

        // Backpressure mid-stream
        fork
            for (int k = 0; k < 8; k++) send({1'b0, 8'(k), 23'h0}, {1'b0, 8'(k + 127), 23'h0});
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Table write on the same edge as an accept: that word sees the old coefficient
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = {26'h300_0000, 35'h0};
        send(32'h0, 32'h3F80_0000);
        cfg_we = 1'b0;
        send(32'h0, 32'h3FC0_0000);
        cfg_write(6'd0, {26'h200_0003, 35'h0});
        send(32'h0, rnd_exp);
        wait_drain();

        // Reset with three words in flight flushes them; table survives
        for (int i = 0; i < 3; i++) send(32'h0, rnd_exp);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_flush", 32'(seen), 32'h0);
        @(posedge clk);
        #1;
        send(32'h0, rnd_exp);
        wait_drain();

        // Randomized table and traffic against the model
        for (int a = 0; a < 64; a++)
            cfg_write(6'(a), {1'b1, 25'($urandom), 21'($urandom), 14'($urandom)});
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] d;
            logic [7:0]  codes [5];
            codes[0] = 8'h0F; codes[1] = 8'hF0; codes[2] = 8'h00; codes[3] = 8'hFF;
            codes[4] = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = {1'b1, codes[$urandom_range(0, 4)], 23'($urandom)};
            else                           d = {1'b0, 31'($urandom)};
            send(d, model(d));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
